// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//   DEPTH x DW register file for the core datapath: two combinational read
//   ports, one clocked write port, a separately enabled NF-bit ALU flag
//   register, an optional hard-wired zero entry 0, and a clear sequencer
//   that zeroes one entry per cycle after reset.
//
// Parameters
//   DW       data width of each entry
//   AW       address width, DEPTH = 2**AW
//   NF       flag width (bit0 zero, bit1 negative, bit2 shift-carry)
//   R0_ZERO  1: entry 0 reads 0 and ignores writes; 0: normal storage
//
// Build option
//   REGF_BYPASS_EN  when defined, a RUN-state write is forwarded to any read
//                   port addressing the same entry in the same cycle.
//                   When undefined, reads show the old contents until the
//                   posedge.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   reset     in   synchronous active-high reset, highest priority
//   wr_en     in   write enable
//   wr_addr   in   write address (AW)
//   dat_in    in   write data (DW)
//   flg_we    in   flag register write enable, independent of wr_en
//   flg_in    in   flag values from the ALU (NF)
//   rd_addrA  in   read address, port A (AW)
//   rd_addrB  in   read address, port B (AW)
//   datA_out  out  read data, port A, combinational (DW)
//   datB_out  out  read data, port B, combinational (DW)
//   flg_out   out  stored flags (NF)
//   busy      out  high while the clear sequencer runs (state == CLEAR)
//
// Handshake: there is none beyond busy. While busy is high every write and
// flag update is dropped (not queued) and both read ports return 0; once busy
// falls every input is honoured on the cycle it is presented.
// -----------------------------------------------------------------------------
module reg_file_param #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int NF      = 3,
    parameter int R0_ZERO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] dat_in,
    input  logic          flg_we,
    input  logic [NF-1:0] flg_in,
    input  logic [AW-1:0] rd_addrA,
    input  logic [AW-1:0] rd_addrB,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic [NF-1:0] flg_out,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] clr_ptr_q, clr_ptr_d;
    logic [NF-1:0] flg_q, flg_d;
    logic [DW-1:0] core_q [DEPTH];

    logic run;
    logic wr_fire;

    assign run = (state_q == ST_RUN);

    // A write only takes effect in RUN, and never to entry 0 when it is
    // hard-wired to zero. The same qualifier gates forwarding, so a
    // discarded write can never be seen on a read port.
    assign wr_fire = run && wr_en && !((R0_ZERO != 0) && (wr_addr == '0));

    // ---------------------------------------------------------------------
    // State, clear pointer and flag registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            flg_q     <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            flg_q     <= flg_d;
        end
    end

    // Next-state logic. The pointer holds at DEPTH-1 when leaving CLEAR so
    // it never wraps; the next reset returns it to 0.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        flg_d     = flg_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_ptr_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    clr_ptr_d = clr_ptr_q + AW'(1);
                end
            end
            ST_RUN: begin
                if (flg_we) begin
                    flg_d = flg_in;
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Storage array. Not reset directly: the clear sequencer zeroes it one
    // entry per cycle, and reads are forced to 0 until it finishes, so the
    // undefined power-up contents are never observable.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                core_q[clr_ptr_q] <= '0;
            end else if (wr_fire) begin
                core_q[wr_addr] <= dat_in;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------------
    always_comb begin
        datA_out = '0;
        if (run && !((R0_ZERO != 0) && (rd_addrA == '0))) begin
            datA_out = core_q[rd_addrA];
`ifdef REGF_BYPASS_EN
            if (wr_fire && (rd_addrA == wr_addr)) begin
                datA_out = dat_in;
            end
`else
`endif
        end
    end

    always_comb begin
        datB_out = '0;
        if (run && !((R0_ZERO != 0) && (rd_addrB == '0))) begin
            datB_out = core_q[rd_addrB];
`ifdef REGF_BYPASS_EN
            if (wr_fire && (rd_addrB == wr_addr)) begin
                datB_out = dat_in;
            end
`else
`endif
        end
    end

    assign flg_out = flg_q;
    assign busy    = (state_q == ST_CLEAR);

endmodule
